sd_controller_stress_driver: RTL and testbench

SD_CONTROLLER_STRESS_DRIVER -- requirements
Module: sd_controller_stress_driver

---
 rtl/sd_controller_stress_driver_if.sv | 22 ++
 rtl/sd_controller_stress_driver.sv | 191 +++++++++++++++++++
 tb/tb_sd_controller_stress_driver.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_controller_stress_driver_if.sv
// Wishbone-style block bus shared by the SD stress driver and its memory target.
interface wishbone_if #(
    parameter int unsigned BLOCK_BITS = 4096
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [31:0]           addr;
    logic [BLOCK_BITS-1:0] dat_o_p;
    logic [BLOCK_BITS-1:0] dat_i_p;
    logic                  ack;

    modport primary (
        output cyc, stb, we, addr, dat_o_p,
        input  dat_i_p, ack
    );

    modport secondary (
        input  cyc, stb, we, addr, dat_o_p,
        output dat_i_p, ack
    );
endinterface

// File: rtl/sd_controller_stress_driver.sv
// Write/read-back stress driver for an SD block target over a Wishbone-style bus.
// Optional per-transfer ack watchdog is built in when SD_DRIVER_TIMEOUT_EN is defined.
module sd_controller_stress_driver #(
    parameter int unsigned BLOCK_BITS     = 4096,
    parameter int unsigned NUM_TESTS      = 16,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter logic [31:0] ADDR_STRIDE    = 32'h1,
    parameter logic [31:0] SEED           = 32'hACE1_0F0F,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    wishbone_if.primary wb_if_p,
    input  logic        start,
    input  logic        stop_on_error,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] error_count,
    output logic [31:0] fail_addr,
    output logic [15:0] test_driver_state
);
    localparam int unsigned WORDS     = BLOCK_BITS / 32;
    localparam logic [15:0] LAST_TEST = 16'(NUM_TESTS - 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SETUP       = 3'd1,
        WRITE_BLOCK = 3'd2,
        READ_BLOCK  = 3'd3,
        COMPARE     = 3'd4,
        NEXT        = 3'd5,
        DONE        = 3'd6
    } state_t;

    state_t                state;
    logic [15:0]           t;
    logic [31:0]           test_addr;
    logic [BLOCK_BITS-1:0] expected;
    logic [BLOCK_BITS-1:0] readback;
    logic                  stop_latched;

    logic [BLOCK_BITS-1:0] pattern;
    logic [31:0]           next_addr;

    always_comb begin
        pattern = '0;
        for (int unsigned k = 0; k < WORDS; k++) begin
            pattern[32*k +: 32] = SEED ^ {t, k[15:0]};
        end
    end

    assign next_addr         = BASE_ADDR + ADDR_STRIDE * {16'd0, t};
    assign test_driver_state = 16'(state);

`ifdef SD_DRIVER_TIMEOUT_EN
    logic [31:0] timer;
`else
    // TIMEOUT_CYCLES only matters when the watchdog is built in.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            t                <= '0;
            test_addr        <= '0;
            expected         <= '0;
            readback         <= '0;
            stop_latched     <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            error_count      <= '0;
            fail_addr        <= '0;
            wb_if_p.cyc      <= 1'b0;
            wb_if_p.stb      <= 1'b0;
            wb_if_p.we       <= 1'b0;
            wb_if_p.addr     <= '0;
            wb_if_p.dat_o_p  <= '0;
`ifdef SD_DRIVER_TIMEOUT_EN
            timer            <= '0;
`endif
        end else begin
`ifdef SD_DRIVER_TIMEOUT_EN
            timer <= '0;
`endif
            unique case (state)
                IDLE: begin
                    if (start) begin
                        stop_latched <= stop_on_error;
                        busy         <= 1'b1;
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    test_addr       <= next_addr;
                    expected        <= pattern;
                    wb_if_p.cyc     <= 1'b1;
                    wb_if_p.stb     <= 1'b1;
                    wb_if_p.we      <= 1'b1;
                    wb_if_p.addr    <= next_addr;
                    wb_if_p.dat_o_p <= pattern;
                    state           <= WRITE_BLOCK;
                end
                WRITE_BLOCK: begin
                    if (wb_if_p.ack) begin
                        wb_if_p.we      <= 1'b0;
                        wb_if_p.dat_o_p <= '0;
                        state           <= READ_BLOCK;
                    end
                end
                READ_BLOCK: begin
                    if (wb_if_p.ack) begin
                        readback     <= wb_if_p.dat_i_p;
                        wb_if_p.cyc  <= 1'b0;
                        wb_if_p.stb  <= 1'b0;
                        wb_if_p.addr <= '0;
                        state        <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (readback != expected) begin
                        if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
                        if (error_count == 16'd0) fail_addr <= test_addr;
                        if (stop_latched) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b0;
                            state <= DONE;
                        end else begin
                            state <= NEXT;
                        end
                    end else begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (t == LAST_TEST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (error_count == 16'd0);
                        state <= DONE;
                    end else begin
                        t     <= t + 16'd1;
                        state <= SETUP;
                    end
                end
                DONE: begin
                    if (start) begin
                        error_count  <= '0;
                        fail_addr    <= '0;
                        t            <= '0;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        busy         <= 1'b1;
                        stop_latched <= stop_on_error;
                        state        <= SETUP;
                    end
                end
                default: state <= IDLE;
            endcase

`ifdef SD_DRIVER_TIMEOUT_EN
            // Placed after the case so an expired watchdog overrides the bus/state updates above.
            if ((state == WRITE_BLOCK || state == READ_BLOCK) && !wb_if_p.ack) begin
                if (timer == 32'(TIMEOUT_CYCLES - 1)) begin
                    wb_if_p.cyc     <= 1'b0;
                    wb_if_p.stb     <= 1'b0;
                    wb_if_p.we      <= 1'b0;
                    wb_if_p.addr    <= '0;
                    wb_if_p.dat_o_p <= '0;
                    if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
                    if (error_count == 16'd0) fail_addr <= test_addr;
                    if (stop_latched) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                        state <= DONE;
                    end else begin
                        state <= NEXT;
                    end
                end else begin
                    timer <= timer + 32'd1;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_sd_controller_stress_driver.sv
// Directed bench for sd_controller_stress_driver with an ideal 3-cycle-ack memory target.
module tb_sd_controller_stress_driver;
    localparam int unsigned BB   = 64;
    localparam logic [31:0] SEED = 32'hACE1_0F0F;

    logic clock = 1'b0;
    logic reset, start, stop_on_error, start2;
    logic busy, done, pass, busy2, done2, pass2;
    logic [15:0] error_count, error_count2, st, st2;
    logic [31:0] fail_addr, fail_addr2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    wishbone_if #(.BLOCK_BITS(BB)) wb ();
    wishbone_if #(.BLOCK_BITS(BB)) wb2 ();

    sd_controller_stress_driver #(
        .BLOCK_BITS(BB), .NUM_TESTS(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock), .reset(reset), .wb_if_p(wb), .start(start), .stop_on_error(stop_on_error),
        .busy(busy), .done(done), .pass(pass), .error_count(error_count), .fail_addr(fail_addr),
        .test_driver_state(st)
    );

    sd_controller_stress_driver #(
        .BLOCK_BITS(BB), .NUM_TESTS(2), .BASE_ADDR(32'hFFFF_FFFF), .ADDR_STRIDE(32'h1)
    ) dut2 (
        .clock(clock), .reset(reset), .wb_if_p(wb2), .start(start2), .stop_on_error(stop_on_error),
        .busy(busy2), .done(done2), .pass(pass2), .error_count(error_count2), .fail_addr(fail_addr2),
        .test_driver_state(st2)
    );

    // Memory target for dut: acks on the third cycle of a request, logs every acked transfer.
    logic [BB-1:0] mem [4];
    logic          corrupt = 1'b0;
    logic          no_ack_t0 = 1'b0;
    int unsigned   cnt = 0;
    logic          log_we   [256];
    logic [31:0]   log_addr [256];
    logic [BB-1:0] log_data [256];
    int unsigned   log_n = 0;

    assign wb.dat_i_p = mem[wb.addr[1:0]] ^ ((corrupt && wb.addr == 32'd2) ? BB'(1) : '0);

    always @(posedge clock) begin
        if (wb.cyc && wb.stb && !wb.ack) begin
            if (cnt == 2 && !(no_ack_t0 && wb.we && wb.addr == 32'd0)) begin
                wb.ack <= 1'b1;
                cnt    <= 0;
                log_we[log_n[7:0]]   <= wb.we;
                log_addr[log_n[7:0]] <= wb.addr;
                log_data[log_n[7:0]] <= wb.dat_o_p;
                log_n <= log_n + 1;
                if (wb.we) mem[wb.addr[1:0]] <= wb.dat_o_p;
            end else if (cnt < 2) begin
                cnt <= cnt + 1;
            end
        end else begin
            wb.ack <= 1'b0;
            cnt    <= 0;
        end
    end

    // Target for dut2: a single block register suffices because every read follows its write.
    logic [BB-1:0] mem2;
    int unsigned   cnt2 = 0;
    logic          log2_we   [16];
    logic [31:0]   log2_addr [16];
    int unsigned   log2_n = 0;

    assign wb2.dat_i_p = mem2;

    always @(posedge clock) begin
        if (wb2.cyc && wb2.stb && !wb2.ack) begin
            if (cnt2 == 2) begin
                wb2.ack <= 1'b1;
                cnt2    <= 0;
                log2_we[log2_n[3:0]]   <= wb2.we;
                log2_addr[log2_n[3:0]] <= wb2.addr;
                log2_n <= log2_n + 1;
                if (wb2.we) mem2 <= wb2.dat_o_p;
            end else begin
                cnt2 <= cnt2 + 1;
            end
        end else begin
            wb2.ack <= 1'b0;
            cnt2    <= 0;
        end
    end

    function automatic logic [BB-1:0] pat(input int unsigned t);
        logic [BB-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < BB / 32; k++) r[32*k +: 32] = SEED ^ {t[15:0], k[15:0]};
        return r;
    endfunction

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(posedge clock); #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        vectors++; if (st !== 16'd0) begin miscompares++; $display("FAIL reset_state got %0d exp 0", st); end
        vectors++; if (wb.cyc !== 1'b0 || wb.stb !== 1'b0 || wb.we !== 1'b0) begin miscompares++; $display("FAIL reset_bus got cyc=%b stb=%b we=%b exp 000", wb.cyc, wb.stb, wb.we); end
        vectors++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin miscompares++; $display("FAIL reset_flags got busy=%b done=%b pass=%b exp 000", busy, done, pass); end
        vectors++; if (error_count !== 16'd0 || fail_addr !== 32'd0) begin miscompares++; $display("FAIL reset_counts got ec=%0d fa=%h exp 0/0", error_count, fail_addr); end
        vectors++; if (wb.addr !== 32'd0 || wb.dat_o_p !== '0) begin miscompares++; $display("FAIL reset_addr_data got addr=%h dat=%h exp 0", wb.addr, wb.dat_o_p); end
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        vectors++; if (st !== 16'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL idle_hold got st=%0d busy=%b exp 0/0", st, busy); end
    endtask

    task automatic test_ideal_run();
        int unsigned base;
        bit ok;
        corrupt = 1'b0; stop_on_error = 1'b0; base = log_n;
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1;
        vectors++; if (st !== 16'd1 || busy !== 1'b1) begin miscompares++; $display("FAIL setup_entry got st=%0d busy=%b exp 1/1", st, busy); end
        @(negedge clock); start = 1'b0;
        @(posedge clock); #1;
        vectors++; if (st !== 16'd2 || wb.cyc !== 1'b1 || wb.stb !== 1'b1 || wb.we !== 1'b1) begin miscompares++; $display("FAIL write_entry got st=%0d cyc=%b stb=%b we=%b exp 2/1/1/1", st, wb.cyc, wb.stb, wb.we); end
        vectors++; if (wb.addr !== 32'd0 || wb.dat_o_p !== 64'hACE10F0E_ACE10F0F) begin miscompares++; $display("FAIL write0_data got addr=%h dat=%h exp 0/ace10f0eace10f0f", wb.addr, wb.dat_o_p); end
        pulse_start();  // ignored while busy
        wait_done(500, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL ideal_done_timeout got done=%b exp 1", done); end
        vectors++; if (pass !== 1'b1 || error_count !== 16'd0 || fail_addr !== 32'd0) begin miscompares++; $display("FAIL ideal_result got pass=%b ec=%0d fa=%h exp 1/0/0", pass, error_count, fail_addr); end
        vectors++; if (busy !== 1'b0 || st !== 16'd6 || wb.cyc !== 1'b0) begin miscompares++; $display("FAIL ideal_done_state got busy=%b st=%0d cyc=%b exp 0/6/0", busy, st, wb.cyc); end
        vectors++; if (log_n - base !== 8) begin miscompares++; $display("FAIL ideal_xfer_count got %0d exp 8", log_n - base); end
        for (int unsigned i = 0; i < 4; i++) begin
            vectors++; if (log_we[(base+2*i)%256] !== 1'b1 || log_addr[(base+2*i)%256] !== i || log_data[(base+2*i)%256] !== pat(i)) begin miscompares++; $display("FAIL ideal_write%0d got we=%b addr=%h dat=%h exp 1/%h/%h", i, log_we[(base+2*i)%256], log_addr[(base+2*i)%256], log_data[(base+2*i)%256], i, pat(i)); end
            vectors++; if (log_we[(base+2*i+1)%256] !== 1'b0 || log_addr[(base+2*i+1)%256] !== i) begin miscompares++; $display("FAIL ideal_read%0d got we=%b addr=%h exp 0/%h", i, log_we[(base+2*i+1)%256], log_addr[(base+2*i+1)%256], i); end
        end
    endtask

    task automatic test_corrupt_continue();
        int unsigned base;
        bit ok;
        corrupt = 1'b1; stop_on_error = 1'b0; base = log_n;
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1;
        vectors++; if (done !== 1'b0 || st !== 16'd1) begin miscompares++; $display("FAIL restart_from_done got done=%b st=%0d exp 0/1", done, st); end
        @(negedge clock); start = 1'b0;
        wait_done(500, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL cont_done_timeout got done=%b exp 1", done); end
        vectors++; if (error_count !== 16'd1 || fail_addr !== 32'd2 || pass !== 1'b0) begin miscompares++; $display("FAIL cont_result got ec=%0d fa=%h pass=%b exp 1/2/0", error_count, fail_addr, pass); end
        vectors++; if (log_n - base !== 8 || log_addr[(base+7)%256] !== 32'd3) begin miscompares++; $display("FAIL cont_all_tests got n=%0d last=%h exp 8/3", log_n - base, log_addr[(base+7)%256]); end
    endtask

    task automatic test_corrupt_stop();
        int unsigned base;
        bit ok;
        bit saw3;
        corrupt = 1'b1; stop_on_error = 1'b1; base = log_n;
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1;
        vectors++; if (error_count !== 16'd0 || fail_addr !== 32'd0) begin miscompares++; $display("FAIL restart_clear got ec=%0d fa=%h exp 0/0", error_count, fail_addr); end
        @(negedge clock); start = 1'b0; stop_on_error = 1'b0;  // latched value must persist
        wait_done(500, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL stop_done_timeout got done=%b exp 1", done); end
        vectors++; if (error_count !== 16'd1 || fail_addr !== 32'd2 || pass !== 1'b0 || st !== 16'd6) begin miscompares++; $display("FAIL stop_result got ec=%0d fa=%h pass=%b st=%0d exp 1/2/0/6", error_count, fail_addr, pass, st); end
        saw3 = 1'b0;
        for (int unsigned i = base; i < log_n; i++) if (log_addr[i%256] == 32'd3) saw3 = 1'b1;
        vectors++; if (log_n - base !== 6 || saw3 !== 1'b0) begin miscompares++; $display("FAIL stop_no_test3 got n=%0d saw3=%b exp 6/0", log_n - base, saw3); end
    endtask

    task automatic test_reset_mid_write();
        int unsigned base;
        bit ok;
        bit seen;
        corrupt = 1'b0; stop_on_error = 1'b0;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clock);
            if (wb.cyc && wb.we) seen = 1'b1;
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL midwrite_reach got seen=%b exp 1", seen); end
        reset = 1'b1;
        #1;
        vectors++; if (wb.cyc !== 1'b0 || wb.stb !== 1'b0 || st !== 16'd0) begin miscompares++; $display("FAIL midwrite_reset got cyc=%b stb=%b st=%0d exp 0/0/0", wb.cyc, wb.stb, st); end
        vectors++; if (busy !== 1'b0 || wb.addr !== 32'd0 || wb.dat_o_p !== '0) begin miscompares++; $display("FAIL midwrite_reset_bus got busy=%b addr=%h dat=%h exp 0/0/0", busy, wb.addr, wb.dat_o_p); end
        @(negedge clock); reset = 1'b0;
        repeat (2) @(negedge clock);
        base = log_n;
        pulse_start();
        wait_done(500, ok);
        vectors++; if (!ok || pass !== 1'b1 || error_count !== 16'd0 || log_n - base !== 8) begin miscompares++; $display("FAIL after_reset_run got ok=%b pass=%b ec=%0d n=%0d exp 1/1/0/8", ok, pass, error_count, log_n - base); end
    endtask

`ifdef SD_DRIVER_TIMEOUT_EN
    task automatic test_timeout();
        int unsigned base;
        int cyc_cnt;
        bit ok;
        corrupt = 1'b0; stop_on_error = 1'b0; no_ack_t0 = 1'b1; base = log_n;
        pulse_start();
        cyc_cnt = 0; ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clock);
            if (wb.cyc && wb.we && wb.addr == 32'd0) cyc_cnt++;
            if (done) ok = 1'b1;
        end
        no_ack_t0 = 1'b0;
        vectors++; if (!ok) begin miscompares++; $display("FAIL timeout_done got done=%b exp 1", done); end
        vectors++; if (cyc_cnt !== 8) begin miscompares++; $display("FAIL timeout_cycles got %0d exp 8", cyc_cnt); end
        vectors++; if (error_count !== 16'd1 || fail_addr !== 32'd0 || pass !== 1'b0) begin miscompares++; $display("FAIL timeout_result got ec=%0d fa=%h pass=%b exp 1/0/0", error_count, fail_addr, pass); end
        vectors++; if (log_n - base !== 6 || log_addr[base%256] !== 32'd1 || log_we[base%256] !== 1'b1) begin miscompares++; $display("FAIL timeout_proceeds got n=%0d first=%h exp 6/1", log_n - base, log_addr[base%256]); end
    endtask
`endif

    task automatic test_addr_wrap();
        bit ok;
        logic [31:0] exp_addr [4];
        logic        exp_we   [4];
        exp_addr[0] = 32'hFFFF_FFFF; exp_addr[1] = 32'hFFFF_FFFF; exp_addr[2] = 32'h0; exp_addr[3] = 32'h0;
        exp_we[0] = 1'b1; exp_we[1] = 1'b0; exp_we[2] = 1'b1; exp_we[3] = 1'b0;
        @(negedge clock); start2 = 1'b1;
        @(negedge clock); start2 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clock); #1;
            if (done2) ok = 1'b1;
        end
        vectors++; if (!ok || pass2 !== 1'b1 || error_count2 !== 16'd0) begin miscompares++; $display("FAIL wrap_result got ok=%b pass=%b ec=%0d exp 1/1/0", ok, pass2, error_count2); end
        vectors++; if (log2_n !== 4) begin miscompares++; $display("FAIL wrap_count got %0d exp 4", log2_n); end
        for (int unsigned i = 0; i < 4; i++) begin
            vectors++; if (log2_addr[i] !== exp_addr[i] || log2_we[i] !== exp_we[i]) begin miscompares++; $display("FAIL wrap_xfer%0d got addr=%h we=%b exp %h/%b", i, log2_addr[i], log2_we[i], exp_addr[i], exp_we[i]); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start2 = 1'b0; stop_on_error = 1'b0;
        test_reset();
        test_ideal_run();
        test_corrupt_continue();
        test_corrupt_stop();
        test_reset_mid_write();
`ifdef SD_DRIVER_TIMEOUT_EN
        test_timeout();
`endif
        test_addr_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "bench time limit exceeded");
    end
endmodule
